// File: rtl/dac_spi_frame_writer.sv
// dac_spi_frame_writer
//   Shifts one complete DAC word out as a single chip-select frame. Frames
//   are separated by a minimum CS_n-high gap. A word strobed in while a
//   frame is in flight is parked in a one-deep pending register. A newer
//   strobe replaces an older parked word, so the DAC always receives the
//   latest value.
//
// Ports
//   i_Clk          system clock
//   i_Rst_L        asynchronous active-low reset
//   i_Data         word to transmit
//   i_DV           single-cycle strobe qualifying i_Data
//   o_Busy         high from frame start until return to IDLE
//   o_Done         one-cycle pulse on the first GAP cycle of each frame
//   o_Overwrite    one-cycle pulse when an unsent pending word is replaced
//   o_Frame_Count  completed frames, wraps 0xFFFF -> 0
//   o_SPI_Clk      SCLK
//   o_SPI_MOSI     serial data
//   o_SPI_CS_n     active-low chip select
//
// state   | meaning
// --------+---------------------------------------------------------------
// S_IDLE  | CS_n high, waiting for i_DV
// S_SETUP | CS_n low, first bit on MOSI, SCLK parked at CPOL
// S_SHIFT | 2*DATA_WIDTH SCLK half-periods; the first edge is on entry
// S_HOLD  | CS_n low after the last edge, MOSI holds the last bit
// S_GAP   | CS_n high; the last cycle launches a pending word or goes idle

module dac_spi_frame_writer #(
  parameter int DATA_WIDTH        = 16,
  parameter int CLKS_PER_HALF_BIT = 2,
  parameter int SPI_MODE          = 0,
  parameter int MSB_FIRST         = 1,
  parameter int CS_SETUP_CLKS     = 2,
  parameter int CS_HOLD_CLKS      = 2,
  parameter int INTER_FRAME_CLKS  = 4
) (
  input  logic                  i_Clk,
  input  logic                  i_Rst_L,
  input  logic [DATA_WIDTH-1:0] i_Data,
  input  logic                  i_DV,
  output logic                  o_Busy,
  output logic                  o_Done,
  output logic                  o_Overwrite,
  output logic [15:0]           o_Frame_Count,
  output logic                  o_SPI_Clk,
  output logic                  o_SPI_MOSI,
  output logic                  o_SPI_CS_n
);

  localparam logic CPOL      = (SPI_MODE == 2) || (SPI_MODE == 3);
  localparam logic CPHA      = (SPI_MODE == 1) || (SPI_MODE == 3);
  localparam int   NUM_EDGES = 2 * DATA_WIDTH;
  localparam int   EDGE_W    = $clog2(NUM_EDGES + 1);
  localparam int   HALF_W    = $clog2(CLKS_PER_HALF_BIT + 1);
  localparam int   TMAX_SH   = (CS_SETUP_CLKS > CS_HOLD_CLKS) ? CS_SETUP_CLKS : CS_HOLD_CLKS;
  localparam int   TMAX      = (TMAX_SH > INTER_FRAME_CLKS) ? TMAX_SH : INTER_FRAME_CLKS;
  localparam int   CNT_W     = $clog2(TMAX + 1);

  generate
    if (DATA_WIDTH < 4 || DATA_WIDTH > 32 || CLKS_PER_HALF_BIT < 1 ||
        SPI_MODE < 0 || SPI_MODE > 3 || MSB_FIRST < 0 || MSB_FIRST > 1 ||
        CS_SETUP_CLKS < 1 || CS_HOLD_CLKS < 1 || INTER_FRAME_CLKS < 1) begin : g_param_check
      $error("dac_spi_frame_writer: parameter out of range");
    end
  endgenerate

  typedef enum logic [2:0] {
    S_IDLE,
    S_SETUP,
    S_SHIFT,
    S_HOLD,
    S_GAP
  } state_t;

  state_t                r_state, w_state_nx;
  logic [CNT_W-1:0]      r_cnt, w_cnt_nx;
  logic [HALF_W-1:0]     r_half, w_half_nx;
  logic [EDGE_W-1:0]     r_edges, w_edges_nx;
  logic [DATA_WIDTH-1:0] r_shift, w_shift_nx;
  logic [DATA_WIDTH-1:0] r_pend, w_pend_nx;
  logic                  r_pend_vld, w_pend_vld_nx;
  logic                  r_busy, w_busy_nx;
  logic                  r_done, w_done_nx;
  logic                  r_ovw, w_ovw_nx;
  logic                  r_sclk, w_sclk_nx;
  logic                  r_mosi, w_mosi_nx;
  logic                  r_cs_n, w_cs_n_nx;
  logic [15:0]           r_frame_count;

  logic [DATA_WIDTH-1:0] w_shift_adv;
  logic [DATA_WIDTH-1:0] w_launch_word;
  logic                  w_data_edge;

  function automatic logic first_bit(input logic [DATA_WIDTH-1:0] d);
    return (MSB_FIRST != 0) ? d[DATA_WIDTH-1] : d[0];
  endfunction

  assign w_shift_adv = (MSB_FIRST != 0) ? {r_shift[DATA_WIDTH-2:0], 1'b0}
                                        : {1'b0, r_shift[DATA_WIDTH-1:1]};

  // r_edges is the index of the edge about to be produced. Edge 0 happens on
  // SHIFT entry, and even-numbered edges are leading edges. CPHA=0 advances
  // data on trailing edges, except after the last bit. CPHA=1 advances data
  // on leading edges after the first, because bit 0 is already on MOSI from
  // CS_n fall.
  assign w_data_edge = CPHA ? (~r_edges[0] && (r_edges != '0))
                            : (r_edges[0] && (r_edges != EDGE_W'(NUM_EDGES - 1)));

  // A strobe on the last GAP cycle takes priority over the parked word.
  assign w_launch_word = i_DV ? i_Data : r_pend;

  always_ff @(posedge i_Clk or negedge i_Rst_L) begin
    if (!i_Rst_L) begin
      r_state       <= S_IDLE;
      r_cnt         <= '0;
      r_half        <= '0;
      r_edges       <= '0;
      r_shift       <= '0;
      r_pend        <= '0;
      r_pend_vld    <= 1'b0;
      r_busy        <= 1'b0;
      r_done        <= 1'b0;
      r_ovw         <= 1'b0;
      r_sclk        <= CPOL;
      r_mosi        <= 1'b0;
      r_cs_n        <= 1'b1;
      r_frame_count <= '0;
    end else begin
      r_state    <= w_state_nx;
      r_cnt      <= w_cnt_nx;
      r_half     <= w_half_nx;
      r_edges    <= w_edges_nx;
      r_shift    <= w_shift_nx;
      r_pend     <= w_pend_nx;
      r_pend_vld <= w_pend_vld_nx;
      r_busy     <= w_busy_nx;
      r_done     <= w_done_nx;
      r_ovw      <= w_ovw_nx;
      r_sclk     <= w_sclk_nx;
      r_mosi     <= w_mosi_nx;
      r_cs_n     <= w_cs_n_nx;
      if (w_done_nx) begin
        r_frame_count <= r_frame_count + 16'd1;
      end
    end
  end

  always_comb begin
    w_state_nx    = r_state;
    w_cnt_nx      = r_cnt;
    w_half_nx     = r_half;
    w_edges_nx    = r_edges;
    w_shift_nx    = r_shift;
    w_pend_nx     = r_pend;
    w_pend_vld_nx = r_pend_vld;
    w_busy_nx     = r_busy;
    w_done_nx     = 1'b0;
    w_ovw_nx      = 1'b0;
    w_sclk_nx     = r_sclk;
    w_mosi_nx     = r_mosi;
    w_cs_n_nx     = r_cs_n;

    // The frame in flight lives in r_shift; strobes outside IDLE only touch
    // the pending register.
    if (i_DV && (r_state != S_IDLE)) begin
      w_pend_nx     = i_Data;
      w_pend_vld_nx = 1'b1;
      w_ovw_nx      = r_pend_vld;
    end

    case (r_state)
      S_IDLE: begin
        if (i_DV) begin
          w_state_nx = S_SETUP;
          w_shift_nx = i_Data;
          w_mosi_nx  = first_bit(i_Data);
          w_cs_n_nx  = 1'b0;
          w_busy_nx  = 1'b1;
          w_sclk_nx  = CPOL;
          w_cnt_nx   = CNT_W'(CS_SETUP_CLKS - 1);
        end
      end
      S_SETUP: begin
        if (r_cnt == '0) begin
          w_state_nx = S_SHIFT;
          w_sclk_nx  = ~CPOL;
          w_edges_nx = EDGE_W'(1);
          w_half_nx  = HALF_W'(CLKS_PER_HALF_BIT - 1);
        end else begin
          w_cnt_nx = r_cnt - CNT_W'(1);
        end
      end
      S_SHIFT: begin
        if (r_half == '0) begin
          if (r_edges == EDGE_W'(NUM_EDGES)) begin
            w_state_nx = S_HOLD;
            w_cnt_nx   = CNT_W'(CS_HOLD_CLKS - 1);
          end else begin
            w_sclk_nx  = ~r_sclk;
            w_edges_nx = r_edges + EDGE_W'(1);
            w_half_nx  = HALF_W'(CLKS_PER_HALF_BIT - 1);
            if (w_data_edge) begin
              w_shift_nx = w_shift_adv;
              w_mosi_nx  = first_bit(w_shift_adv);
            end
          end
        end else begin
          w_half_nx = r_half - HALF_W'(1);
        end
      end
      S_HOLD: begin
        if (r_cnt == '0) begin
          w_state_nx = S_GAP;
          w_cs_n_nx  = 1'b1;
          w_done_nx  = 1'b1;
          w_mosi_nx  = 1'b0;
          w_cnt_nx   = CNT_W'(INTER_FRAME_CLKS - 1);
        end else begin
          w_cnt_nx = r_cnt - CNT_W'(1);
        end
      end
      S_GAP: begin
        if (r_cnt == '0) begin
          if (i_DV || r_pend_vld) begin
            w_state_nx    = S_SETUP;
            w_shift_nx    = w_launch_word;
            w_mosi_nx     = first_bit(w_launch_word);
            w_cs_n_nx     = 1'b0;
            w_cnt_nx      = CNT_W'(CS_SETUP_CLKS - 1);
            w_pend_vld_nx = 1'b0;
            w_ovw_nx      = i_DV && r_pend_vld;
          end else begin
            w_state_nx = S_IDLE;
            w_busy_nx  = 1'b0;
          end
        end else begin
          w_cnt_nx = r_cnt - CNT_W'(1);
        end
      end
      default: begin
        w_state_nx = S_IDLE;
      end
    endcase
  end

  assign o_Busy        = r_busy;
  assign o_Done        = r_done;
  assign o_Overwrite   = r_ovw;
  assign o_Frame_Count = r_frame_count;
  assign o_SPI_Clk     = r_sclk;
  assign o_SPI_MOSI    = r_mosi;
  assign o_SPI_CS_n    = r_cs_n;

endmodule
